// File: rtl/rv_pkg.sv
// Shared fetch-side definitions: datapath width, default reset vector and fetch FSM states.
package rv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          INSTR_BYTES  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit.sv
// Single-outstanding instruction fetch: PC register, imem request/response sequencing,
// decode-side valid/ready hold, and redirect handling with wrong-path drain.
module inst_fetch_unit
    import rv_pkg::*;
#(
    parameter int               XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [XLEN-1:0]  imem_rsp_data,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [XLEN-1:0]  instr_data,
    output logic [XLEN-1:0]  instr_pc,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             misalign_pulse
);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            latch_rsp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            instr_data     <= '0;
            instr_pc       <= '0;
            misalign_pulse <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            misalign_pulse <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (latch_rsp) begin
                instr_data <= imem_rsp_data;
                instr_pc   <= pc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        latch_rsp = 1'b0;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   if (imem_req_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = S_HOLD;
                    latch_rsp = 1'b1;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    state_nxt = S_REQ;
                    pc_nxt    = pc + XLEN'(INSTR_BYTES);
                end
            end
            S_DRAIN: if (imem_rsp_valid) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase

        // Redirect overrides everything; any accepted-but-unanswered request must be drained.
        if (redirect_valid) begin
            pc_nxt    = {redirect_pc[XLEN-1:2], 2'b00};
            latch_rsp = 1'b0;
            case (state)
                S_REQ:          state_nxt = imem_req_ready ? S_DRAIN : S_REQ;
                S_WAIT, S_DRAIN: state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
                default:        state_nxt = S_REQ;
            endcase
        end
    end

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign instr_valid    = (state == S_HOLD);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: per-cycle vector table plus hand sequences for
// wrong-path drain, PC wrap, redirect on accepted request and mid-flight reset.
module tb_inst_fetch_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_data;
    logic [XLEN-1:0] instr_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            misalign_pulse;

    inst_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_pulse (misalign_pulse)
    );

    always #5 clk = ~clk;

    // Memory model: one response, mem_lat cycles after the cycle following acceptance.
    logic            pend;
    int unsigned     cnt;
    int unsigned     mem_lat;
    logic [XLEN-1:0] mem_word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            cnt  <= 0;
        end else begin
            if (pend) begin
                if (cnt == 0) pend <= 1'b0;
                else          cnt  <= cnt - 1;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend <= 1'b1;
                cnt  <= mem_lat;
            end
        end
    end

    assign imem_rsp_valid = pend && (cnt == 0);
    assign imem_rsp_data  = mem_word;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic            ir;
        logic            mr;
        logic            rd;
        logic [XLEN-1:0] rpc;
        logic            rv;
        logic [XLEN-1:0] ra;
        logic            iv;
        logic [XLEN-1:0] ipc;
        logic            mis;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic mr, input logic rd,
                                input logic [XLEN-1:0] rpc, input logic rv,
                                input logic [XLEN-1:0] ra, input logic iv,
                                input logic [XLEN-1:0] ipc, input logic mis);
        vec_t v;
        v.ir = ir; v.mr = mr; v.rd = rd; v.rpc = rpc;
        v.rv = rv; v.ra = ra; v.iv = iv; v.ipc = ipc; v.mis = mis;
        return v;
    endfunction

    vec_t tbl[23];

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             ir  mr  rd  rpc           rv  ra            iv  ipc           mis
        tbl[0]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0); // IDLE
        tbl[1]  = mk(1, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0); // REQ 0
        tbl[2]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0); // WAIT
        tbl[3]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0); // HOLD pc0
        tbl[4]  = mk(1, 1, 0, 32'h0,        1, 32'h4,        0, 32'h0,        0);
        tbl[5]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        tbl[6]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0); // stall x5
        tbl[7]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0);
        tbl[8]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0);
        tbl[9]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0);
        tbl[10] = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0);
        tbl[11] = mk(1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0); // release
        tbl[12] = mk(1, 1, 0, 32'h0,        1, 32'h8,        0, 32'h0,        0);
        tbl[13] = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        tbl[14] = mk(1, 1, 1, 32'h40,       0, 32'h0,        1, 32'h8,        0); // redirect+ready in HOLD
        tbl[15] = mk(1, 1, 0, 32'h0,        1, 32'h40,       0, 32'h0,        0);
        tbl[16] = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        tbl[17] = mk(1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h40,       0);
        tbl[18] = mk(1, 0, 1, 32'h82,       1, 32'h44,       0, 32'h0,        0); // misaligned redirect
        tbl[19] = mk(1, 1, 0, 32'h0,        1, 32'h80,       0, 32'h0,        1);
        tbl[20] = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        tbl[21] = mk(1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h80,       0);
        tbl[22] = mk(1, 0, 0, 32'h0,        1, 32'h84,       0, 32'h0,        0);

        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_lat        = 0;
        mem_word       = 32'h0000_0013;

        #12;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_misalign", {31'b0, misalign_pulse}, 32'h0);
        chk("rst_instr_data", instr_data, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            chk($sformatf("v%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].rv});
            if (tbl[i].rv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, tbl[i].ra);
            chk($sformatf("v%0d_instr_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].iv});
            if (tbl[i].iv) begin
                chk($sformatf("v%0d_instr_pc", i), instr_pc, tbl[i].ipc);
                chk($sformatf("v%0d_instr_data", i), instr_data, 32'h0000_0013);
            end
            chk($sformatf("v%0d_misalign", i), {31'b0, misalign_pulse}, {31'b0, tbl[i].mis});
            instr_ready    = tbl[i].ir;
            imem_req_ready = tbl[i].mr;
            redirect_valid = tbl[i].rd;
            redirect_pc    = tbl[i].rpc;
            step();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;

        // Wrong-path drain: redirect in WAIT, DEADBEEF arrives two cycles later.
        mem_lat  = 2;
        mem_word = 32'hDEAD_BEEF;
        do_reset();
        step();                                            // REQ 0, accepted
        chk("drain_req_addr0", imem_req_addr, 32'h0);
        step();                                            // WAIT
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        chk("drain_iv_a", {31'b0, instr_valid}, 32'h0);
        chk("drain_rv_a", {31'b0, imem_req_valid}, 32'h0);
        step();                                            // response arrives here
        chk("drain_rsp_seen", {31'b0, imem_rsp_valid}, 32'h1);
        chk("drain_iv_b", {31'b0, instr_valid}, 32'h0);
        mem_lat = 0;
        step();
        chk("drain_iv_c", {31'b0, instr_valid}, 32'h0);
        chk("drain_rv_c", {31'b0, imem_req_valid}, 32'h1);
        chk("drain_req_addr", imem_req_addr, 32'h0000_0100);
        mem_word = 32'h0000_0013;
        step();                                            // WAIT
        step();                                            // HOLD
        chk("drain_iv_d", {31'b0, instr_valid}, 32'h1);
        chk("drain_instr_pc", instr_pc, 32'h0000_0100);
        chk("drain_instr_data", instr_data, 32'h0000_0013);

        // PC wrap: redirect to the last word, consume it.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_req_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap_misalign", {31'b0, misalign_pulse}, 32'h0);
        step();
        step();
        chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_rv", {31'b0, imem_req_valid}, 32'h1);
        chk("wrap_req_addr", imem_req_addr, 32'h0000_0000);

        // Redirect in the same cycle the request is accepted: old fetch drained.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        chk("acc_redir_rv", {31'b0, imem_req_valid}, 32'h0);
        chk("acc_redir_iv", {31'b0, instr_valid}, 32'h0);
        step();
        chk("acc_redir_addr", imem_req_addr, 32'h0000_0200);
        chk("acc_redir_rv2", {31'b0, imem_req_valid}, 32'h1);
        step();                                            // WAIT with 0x200 outstanding

        // Asynchronous reset in WAIT, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rv", {31'b0, imem_req_valid}, 32'h0);
        chk("mid_rst_iv", {31'b0, instr_valid}, 32'h0);
        chk("mid_rst_data", instr_data, 32'h0);
        chk("mid_rst_pc", instr_pc, 32'h0);
        chk("mid_rst_mis", {31'b0, misalign_pulse}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_idle", {31'b0, imem_req_valid}, 32'h0);
        step();
        chk("post_rst_rv", {31'b0, imem_req_valid}, 32'h1);
        chk("post_rst_addr", imem_req_addr, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
